cpu_system_irq_ctrl: RTL and testbench
======================================

# cpu_system_irq_ctrl

Avalon-MM interrupt controller that sits directly downstream of the interval timer and the other CPU_System peripherals. It collects their `irq` outputs, latches them into a pending register, and applies a software mask. It drives a single registered interrupt request to the CPU, plus a vector register that identifies the lowest-numbered active source. It shares the peripherals' 16-bit, 3-bit-address slave conventions.

## Interface
- `NUM_SRC`, 8, number of interrupt sources, legal 1..15; the timer connects to bit 0.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  16  write data; bits at and above `NUM_SRC` are ignored.
- `readdata`  out  16  registered read data; unused bits read 0.
- `irq_in`  in  `NUM_SRC`  peripheral interrupt lines, synchronous to `clk`, active-high.
- `irq`  out  1  registered interrupt to the CPU.

## Operation
- Register map:
  - 0 `STATUS` (RO): raw `irq_in`.
  - 1 `PENDING` (R/W1C).
  - 2 `MASK` (RW, 1 = enabled).
  - 3 `ACTIVE` (RO): `PENDING & MASK`.
  - 4 `VECTOR` (RO): bit15 = any active; [3:0] = lowest active index, 0 when none.
  - 5 `EDGE_SEL` (RW, see Configuration).
  - 6 `FORCE` (WO, write-1-to-set `PENDING`; reads 0).
  - 7 reserved: reads 0, writes ignored.
- Write strobe: `chipselect && !write_n`.
- Level source: its pending bit is set every cycle that `irq_in[i]`=1. A W1C clear only takes effect once the source deasserts.
- Edge source: its pending bit is set when `irq_in[i]`=1 and `irq_prev[i]`=0. `irq_prev` is a register updated every cycle.
- Simultaneous set (source event or `FORCE`) and W1C clear on the same bit: set wins.
- `irq` <= |(`PENDING & MASK`), recomputed every cycle.
- Masking does not clear pending. Unmasking an already-pending bit raises `irq` one cycle later.
- The vector uses fixed lowest-index-first priority. There is no in-service state or nesting.
- Arithmetic: all registers are `NUM_SRC` bits, zero-extended to 16 on read.

## Timing
- Reset (any edge with `reset_n`=0) clears the following, regardless of `chipselect`:
  - `readdata`, `irq` = 0
  - `PENDING`, `MASK`, `EDGE_SEL`, `irq_prev` = 0
- Reset asserted mid-pending discards all events. After release, a level source still high re-pends on the first edge.
- Read latency: 1 cycle. `readdata` registers the mux output every cycle, as the timer does.
- Interrupt latency:
  - `irq_in` sampled high at edge E0 sets `PENDING` at E0; `irq` rises at E1.
  - A W1C at edge Ew (source low) clears the bit at Ew; `irq` falls at Ew+1.
- `VECTOR` and `ACTIVE` reflect register state of the same cycle as the read, returned on the next edge.

## Configuration
- `CPU_SYSTEM_IRQ_EDGE_EN` defined:
  - `EDGE_SEL` is implemented (reset 0 = all level).
  - Per-bit 1 selects edge detection.
- Undefined:
  - No `EDGE_SEL` or `irq_prev` flops; all sources are level.
  - Address 5 reads 0 and ignores writes.

## Structure
- Package `cpu_system_irq_pkg`:
  - register address constants (`IRQ_ADDR_STATUS` … `IRQ_ADDR_FORCE`)
  - `IRQ_MAX_SRC`=15
  - `VECTOR` field positions (valid bit 15, index [3:0])
- Sub-module `cpu_system_irq_prio_enc`:
  - combinational, parameterised by `NUM_SRC`
  - inputs: active vector
  - outputs: `valid` and 4-bit lowest-set index
- Top level holds the pending/mask/edge registers, strobes, read mux and output flops.

## Test plan
- Reset, then read all addresses → `readdata`=0 everywhere and `irq`=0. A reset pulse mid-pending → `PENDING`=0, `irq` 0 the following cycle.
- `MASK`=0x01, timer `irq_in[0]` pulses high for 1 cycle (level mode) → `PENDING`=0x0001, `irq` high 1 cycle after, `VECTOR`=0x8000; write 0x0001 to addr 1 → `irq` low after Ew+1.
- `irq_in`=0x0C held high, `MASK`=0xFF → `VECTOR`=0x8002. W1C 0x0C while still high → `PENDING` stays 0x0C (set wins).
- `MASK`=0, `FORCE` 0x80 → `PENDING`=0x80, `irq`=0; then `MASK`=0x80 → `irq`=1 next cycle, `VECTOR`=0x8007.
- With `CPU_SYSTEM_IRQ_EDGE_EN`: `EDGE_SEL`=0x01, `irq_in[0]` held high 20 cycles → pending set once; W1C while still high clears it; no re-set until low→high. Without the macro, addr 5 write 0x01 then read → 0x0000.

Source files
------------

// File: rtl/cpu_system_irq_pkg.sv
// Shared constants for the CPU_System interrupt controller.
// Holds the register map, the source-count ceiling and the VECTOR field layout.
package cpu_system_irq_pkg;

  // Register map (3-bit word address)
  localparam logic [2:0] IRQ_ADDR_STATUS   = 3'd0;
  localparam logic [2:0] IRQ_ADDR_PENDING  = 3'd1;
  localparam logic [2:0] IRQ_ADDR_MASK     = 3'd2;
  localparam logic [2:0] IRQ_ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] IRQ_ADDR_VECTOR   = 3'd4;
  localparam logic [2:0] IRQ_ADDR_EDGE_SEL = 3'd5;
  localparam logic [2:0] IRQ_ADDR_FORCE    = 3'd6;

  // Largest legal NUM_SRC: bit 15 of VECTOR is the valid flag
  localparam int unsigned IRQ_MAX_SRC = 15;

  // VECTOR register fields
  localparam int unsigned IRQ_VEC_VALID_BIT = 15;
  localparam int unsigned IRQ_VEC_IDX_MSB   = 3;
  localparam int unsigned IRQ_VEC_IDX_LSB   = 0;

endpackage

// File: rtl/cpu_system_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt controller.
//   address    : 3-bit register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 16-bit write data
//   readdata   : 16-bit registered read data
// master drives the request side, slave returns readdata.
interface cpu_system_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/cpu_system_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-numbered set bit of the active vector.
//   active : NUM_SRC-bit vector of masked pending sources
//   valid  : any bit of active is set
//   index  : lowest set bit index, 0 when none
module cpu_system_irq_prio_enc #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] active,
  output logic               valid,
  output logic [3:0]         index
);

  // Scan high-to-low so the last hit (the lowest index) wins.
  always_comb begin
    valid = 1'b0;
    index = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        valid = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_system_irq_ctrl.sv
// CPU_System interrupt controller.
// Latches peripheral interrupt lines into PENDING, gates them with MASK and drives a
// registered irq to the CPU plus a VECTOR register naming the lowest active source.
//   clk, reset_n : system clock, synchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   irq_in       : NUM_SRC active-high interrupt lines, synchronous to clk
//   irq          : registered |(PENDING & MASK)
// Build option CPU_SYSTEM_IRQ_EDGE_EN adds the EDGE_SEL register and per-source
// rising-edge detection; without it every source is level and address 5 reads 0.
module cpu_system_irq_ctrl
  import cpu_system_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cpu_system_irq_ctrl_if.slave bus,
  input  logic [NUM_SRC-1:0]   irq_in,
  output logic                 irq
);

  logic               wr_en;
  logic [NUM_SRC-1:0] wdata;
  logic               unused_wdata;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] set_evt;
  logic               prio_valid;
  logic [3:0]         prio_idx;
  logic [15:0]        rdata_d;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[NUM_SRC-1:0];
  // Bits above NUM_SRC are ignored on every write.
  assign unused_wdata = ^bus.writedata[15:NUM_SRC];
  assign active       = pending_q & mask_q;

`ifdef CPU_SYSTEM_IRQ_EDGE_EN
  logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0] irq_prev_q;

  // Edge sources pend only on a low-to-high transition; level sources every cycle high.
  assign set_evt = (irq_in & ~edge_sel_q) | (irq_in & ~irq_prev_q & edge_sel_q);

  always_comb begin
    edge_sel_d = edge_sel_q;
    if (wr_en && (bus.address == IRQ_ADDR_EDGE_SEL)) begin
      edge_sel_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_sel_q <= '0;
      irq_prev_q <= '0;
    end else begin
      edge_sel_q <= edge_sel_d;
      irq_prev_q <= irq_in;
    end
  end
`else
  assign set_evt = irq_in;
`endif

  // Clear first, then OR in sets so a same-cycle set beats a W1C.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    if (wr_en && (bus.address == IRQ_ADDR_PENDING)) begin
      pending_d = pending_d & ~wdata;
    end
    pending_d = pending_d | set_evt;
    if (wr_en && (bus.address == IRQ_ADDR_FORCE)) begin
      pending_d = pending_d | wdata;
    end
    if (wr_en && (bus.address == IRQ_ADDR_MASK)) begin
      mask_d = wdata;
    end
  end

  cpu_system_irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .active (active),
    .valid  (prio_valid),
    .index  (prio_idx)
  );

  always_comb begin
    rdata_d = 16'h0000;
    case (bus.address)
      IRQ_ADDR_STATUS:  rdata_d = 16'(irq_in);
      IRQ_ADDR_PENDING: rdata_d = 16'(pending_q);
      IRQ_ADDR_MASK:    rdata_d = 16'(mask_q);
      IRQ_ADDR_ACTIVE:  rdata_d = 16'(active);
      IRQ_ADDR_VECTOR: begin
        rdata_d[IRQ_VEC_VALID_BIT]               = prio_valid;
        rdata_d[IRQ_VEC_IDX_MSB:IRQ_VEC_IDX_LSB] = prio_idx;
      end
`ifdef CPU_SYSTEM_IRQ_EDGE_EN
      IRQ_ADDR_EDGE_SEL: rdata_d = 16'(edge_sel_q);
`endif
      default:          rdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q    <= '0;
      mask_q       <= '0;
      irq          <= 1'b0;
      bus.readdata <= 16'h0000;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq          <= |active;
      bus.readdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_system_irq_ctrl.sv
// Self-checking bench for cpu_system_irq_ctrl: directed scenarios followed by random
// bus/interrupt traffic, all compared against a per-bit behavioural model.
module tb_cpu_system_irq_ctrl;

  localparam int unsigned NumSrc = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NumSrc-1:0] irq_in;
  logic              irq;

  cpu_system_irq_ctrl_if bus ();

  cpu_system_irq_ctrl #(
    .NUM_SRC (NumSrc)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit [NumSrc-1:0] m_pend, m_mask, m_edge, m_prev;
  bit              m_irq;
  bit [15:0]       m_rd;

`ifdef CPU_SYSTEM_IRQ_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [15:0] model_read(input bit [2:0] a);
    bit [NumSrc-1:0] act;
    act = m_pend & m_mask;
    case (a)
      3'd0: return 16'(irq_in);
      3'd1: return 16'(m_pend);
      3'd2: return 16'(m_mask);
      3'd3: return 16'(act);
      3'd4: begin
        for (int i = 0; i < NumSrc; i++) begin
          if (act[i]) return 16'h8000 | 16'(i);
        end
        return 16'h0000;
      end
      3'd5: return EdgeEn ? 16'(m_edge) : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit              wr;
    bit [NumSrc-1:0] wd, nxt;
    bit              set;
    wr = bus.chipselect && !bus.write_n;
    wd = bus.writedata[NumSrc-1:0];
    if (!reset_n) begin
      m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0;
      m_irq = 1'b0; m_rd = 16'h0000;
      return;
    end
    m_rd  = model_read(bus.address);
    m_irq = |(m_pend & m_mask);
    nxt   = m_pend;
    for (int i = 0; i < NumSrc; i++) begin
      set = (EdgeEn && m_edge[i]) ? (irq_in[i] && !m_prev[i]) : irq_in[i];
      if (wr && bus.address == 3'd6 && wd[i]) set = 1'b1;
      if (set) nxt[i] = 1'b1;
      else if (wr && bus.address == 3'd1 && wd[i]) nxt[i] = 1'b0;
    end
    if (wr && bus.address == 3'd2) m_mask = wd;
    if (EdgeEn && wr && bus.address == 3'd5) m_edge = wd;
    if (EdgeEn) m_prev = irq_in;
    m_pend = nxt;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("irq", 16'(irq), 16'(m_irq));
    check("readdata", bus.readdata, m_rd);
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 16'h0000;
  endtask

  task automatic reg_wr(input bit [2:0] a, input bit [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic reg_rd(input bit [2:0] a, output logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    tick();
    d = bus.readdata;
    bus_idle();
  endtask

  logic [15:0] rd;

  initial begin
    bus_idle();
    irq_in  = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state: every address reads 0, irq low
    for (int a = 0; a < 8; a++) begin
      reg_rd(3'(a), rd);
      check("reset_read", rd, 16'h0000);
    end
    check("reset_irq", 16'(irq), 16'h0000);

    // Timer level pulse, masked in
    reg_wr(3'd2, 16'h0001);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    reg_rd(3'd1, rd);
    check("timer_pending", rd, 16'h0001);
    check("timer_irq", 16'(irq), 16'h0001);
    reg_rd(3'd4, rd);
    check("timer_vector", rd, 16'h8000);
    reg_wr(3'd1, 16'h0001);
    tick();
    check("timer_w1c_irq", 16'(irq), 16'h0000);

    // Held level sources: priority and set-wins-over-W1C
    irq_in = 8'h0C;
    reg_wr(3'd2, 16'h00FF);
    reg_rd(3'd4, rd);
    check("level_vector", rd, 16'h8002);
    reg_wr(3'd1, 16'h000C);
    reg_rd(3'd1, rd);
    check("level_set_wins", rd, 16'h000C);
    irq_in = 8'h00;
    reg_wr(3'd1, 16'h000C);
    reg_rd(3'd1, rd);
    check("level_cleared", rd, 16'h0000);

    // FORCE while masked, then unmask
    reg_wr(3'd2, 16'h0000);
    reg_wr(3'd6, 16'h0080);
    reg_rd(3'd1, rd);
    check("force_pending", rd, 16'h0080);
    check("force_masked_irq", 16'(irq), 16'h0000);
    reg_rd(3'd6, rd);
    check("force_reads_0", rd, 16'h0000);
    reg_wr(3'd2, 16'h0080);
    tick();
    check("unmask_irq", 16'(irq), 16'h0001);
    reg_rd(3'd4, rd);
    check("force_vector", rd, 16'h8007);

    // Reset mid-pending discards everything
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_irq", 16'(irq), 16'h0000);
    reg_rd(3'd1, rd);
    check("midrst_pending", rd, 16'h0000);

`ifdef CPU_SYSTEM_IRQ_EDGE_EN
    reg_wr(3'd5, 16'h0001);
    irq_in = 8'h01;
    for (int i = 0; i < 20; i++) tick();
    reg_rd(3'd1, rd);
    check("edge_pend_once", rd, 16'h0001);
    reg_wr(3'd1, 16'h0001);
    tick();
    reg_rd(3'd1, rd);
    check("edge_w1c_held", rd, 16'h0000);
    irq_in = 8'h00;
    tick();
    irq_in = 8'h01;
    tick();
    reg_rd(3'd1, rd);
    check("edge_rearm", rd, 16'h0001);
    irq_in = 8'h00;
`else
    reg_wr(3'd5, 16'h0001);
    reg_rd(3'd5, rd);
    check("edge_sel_absent", rd, 16'h0000);
`endif

    // Reserved address
    reg_wr(3'd7, 16'hFFFF);
    reg_rd(3'd7, rd);
    check("reserved", rd, 16'h0000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      irq_in         = NumSrc'($urandom) & NumSrc'($urandom) & NumSrc'($urandom);
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = 1'($urandom);
      bus.address    = 3'($urandom);
      bus.writedata  = 16'($urandom);
      reset_n        = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset_n = 1'b1;
    bus_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
